// File: rtl/iluminacao_multizona.sv
// Multi-zone lighting controller. One tick divider is shared by every zone; each zone has
// its own input synchroniser, button debounce, short/long press detector and AUTO/MANUAL lamp FSM.
module iluminacao_multizona #(
    parameter int N_ZONES           = 4,
    parameter int CLK_DIV           = 50000,
    parameter int DEBOUNCE_P        = 300,
    parameter int SWITCH_MODE_MIN_T = 5000,
    parameter int AUTO_SHUTDOWN_T   = 30000,
    parameter int CNT_W             = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_ZONES-1:0] infravermelho,
    input  logic [N_ZONES-1:0] push_button,
    output logic [N_ZONES-1:0] led,
    output logic [N_ZONES-1:0] saida
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_P - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(SWITCH_MODE_MIN_T);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SWITCH_MODE_MIN_T - 1);
    localparam logic [CNT_W-1:0] AST_LAST  = CNT_W'(AUTO_SHUTDOWN_T - 1);

    // Bit 1 is the mode (1 = MANUAL), bit 0 the lamp, so both outputs come straight from the state register.
    localparam logic [1:0] ST_AUTO_OFF   = 2'b00;
    localparam logic [1:0] ST_AUTO_ON    = 2'b01;
    localparam logic [1:0] ST_MANUAL_OFF = 2'b10;
    localparam logic [1:0] ST_MANUAL_ON  = 2'b11;

    logic [DIV_W-1:0]   r_div;
    logic               w_tick;
    logic [N_ZONES-1:0] r_ir_s1;
    logic [N_ZONES-1:0] r_ir_s2;
    logic [N_ZONES-1:0] r_btn_s1;
    logic [N_ZONES-1:0] r_btn_s2;

    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ir_s1  <= '0;
            r_ir_s2  <= '0;
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
        end else begin
            r_ir_s1  <= infravermelho;
            r_ir_s2  <= r_ir_s1;
            r_btn_s1 <= push_button;
            r_btn_s2 <= r_btn_s1;
        end
    end

    for (genvar g = 0; g < N_ZONES; g++) begin : g_zone
        logic             w_ir;
        logic             w_btn;
        logic             w_deb_flip;
        logic             w_long;
        logic             w_short;
        logic             r_deb;
        logic [CNT_W-1:0] r_deb_cnt;
        logic [CNT_W-1:0] r_hold_cnt;
        logic [CNT_W-1:0] r_timer;
        logic [CNT_W-1:0] w_timer_nxt;
        logic [1:0]       r_state;
        logic [1:0]       w_state_nxt;

        assign w_ir       = r_ir_s2[g];
        assign w_btn      = r_btn_s2[g];
        assign w_deb_flip = (w_btn != r_deb) && (r_deb_cnt == DEB_LAST);
        assign w_long     = r_deb && (r_hold_cnt == HOLD_LAST);
        // A release on the same tick the hold completes counts as LONG only, never as SHORT too.
        assign w_short    = w_deb_flip && r_deb && (r_hold_cnt < HOLD_LAST);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_deb     <= 1'b0;
                r_deb_cnt <= '0;
            end else if (w_tick) begin
                if (w_btn == r_deb) begin
                    r_deb_cnt <= '0;
                end else if (w_deb_flip) begin
                    r_deb     <= w_btn;
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_hold_cnt <= '0;
            end else if (w_tick) begin
                if (!r_deb) begin
                    r_hold_cnt <= '0;
                end else if (r_hold_cnt != HOLD_MAX) begin
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                end
            end
        end

        // A long press always wins over presence and timeout on the same tick.
        always_comb begin
            w_state_nxt = r_state;
            w_timer_nxt = r_timer;
            if (w_long) begin
                w_timer_nxt = '0;
                if ((r_state == ST_MANUAL_OFF) || (r_state == ST_MANUAL_ON)) begin
                    w_state_nxt = ST_AUTO_OFF;
                end else begin
                    w_state_nxt = ST_MANUAL_OFF;
                end
            end else begin
                case (r_state)
                    ST_AUTO_OFF: begin
                        if (w_ir) begin
                            w_state_nxt = ST_AUTO_ON;
                            w_timer_nxt = '0;
                        end
                    end
                    ST_AUTO_ON: begin
                        if (w_ir) begin
                            w_timer_nxt = '0;
                        end else if (r_timer >= AST_LAST) begin
                            w_state_nxt = ST_AUTO_OFF;
                            w_timer_nxt = '0;
                        end else begin
                            w_timer_nxt = r_timer + 1'b1;
                        end
                    end
                    ST_MANUAL_OFF: begin
                        if (w_short) begin
                            w_state_nxt = ST_MANUAL_ON;
                        end
                    end
                    ST_MANUAL_ON: begin
                        if (w_short) begin
                            w_state_nxt = ST_MANUAL_OFF;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_AUTO_OFF;
                        w_timer_nxt = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state <= ST_AUTO_OFF;
                r_timer <= '0;
            end else if (w_tick) begin
                r_state <= w_state_nxt;
                r_timer <= w_timer_nxt;
            end
        end

        assign led[g]   = r_state[1];
        assign saida[g] = r_state[0];
    end

endmodule
